// File: rtl/bcd_event_timer.sv
// Prescaled N-digit BCD up/down counter with active-low 7-segment outputs.
// Optional saturating mode: define BCD_TIMER_SAT_EN to hold at the limits instead of wrapping.
module bcd_event_timer #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  tick,
    output logic                  wrap
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]          presc_r;
    logic [4*DIGITS-1:0]    count_r;
    logic                   tick_r;
    logic                   wrap_r;
    logic [4*DIGITS-1:0]    stepped_s;
    logic [4*DIGITS-1:0]    loaded_s;
    logic                   ripple_s;
    logic                   step_s;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        if (d > 4'd9) begin
            return 4'd9;
        end else begin
            return d;
        end
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b100_0000;
            4'd1:    s = 7'b111_1001;
            4'd2:    s = 7'b010_0100;
            4'd3:    s = 7'b011_0000;
            4'd4:    s = 7'b001_1001;
            4'd5:    s = 7'b001_0010;
            4'd6:    s = 7'b000_0010;
            4'd7:    s = 7'b111_1000;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b001_1000;
            default: s = 7'b111_1111;
        endcase
        return s;
    endfunction

    assign step_s = enable && (presc_r == PRESC_MAX);

    // Next count after one step; ripple_s set means every digit rolled over.
    always_comb begin
        stepped_s = count_r;
        ripple_s  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple_s) begin
                if (!down) begin
                    if (count_r[4*i +: 4] == 4'd9) begin
                        stepped_s[4*i +: 4] = 4'd0;
                    end else begin
                        stepped_s[4*i +: 4] = count_r[4*i +: 4] + 4'd1;
                        ripple_s            = 1'b0;
                    end
                end else begin
                    if (count_r[4*i +: 4] == 4'd0) begin
                        stepped_s[4*i +: 4] = 4'd9;
                    end else begin
                        stepped_s[4*i +: 4] = count_r[4*i +: 4] - 4'd1;
                        ripple_s            = 1'b0;
                    end
                end
            end else begin
                stepped_s[4*i +: 4] = count_r[4*i +: 4];
            end
        end
    end

    // Clamp out-of-range load nibbles to 9.
    always_comb begin
        loaded_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            loaded_s[4*i +: 4] = clamp_digit(load_value[4*i +: 4]);
        end
    end

    // Prescaler, count and step-pulse registers; reset > clear > load > step.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_r <= '0;
            count_r <= '0;
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else if (clear) begin
            presc_r <= '0;
            count_r <= '0;
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else if (load) begin
            presc_r <= '0;
            count_r <= loaded_s;
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else if (step_s) begin
            presc_r <= '0;
            tick_r  <= 1'b1;
`ifdef BCD_TIMER_SAT_EN
            count_r <= ripple_s ? count_r : stepped_s;
            wrap_r  <= 1'b0;
`else
            count_r <= stepped_s;
            wrap_r  <= ripple_s;
`endif
        end else if (enable) begin
            presc_r <= presc_r + PW'(1);
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end
    end

    // Segment decode follows the registered count directly.
    always_comb begin
        hex = '1;
        for (int i = 0; i < DIGITS; i++) begin
            hex[7*i +: 7] = seg7(count_r[4*i +: 4]);
        end
    end

    assign count = count_r;
    assign tick  = tick_r;
    assign wrap  = wrap_r;

endmodule
